frame_write_sequencer: RTL
==========================

Name: frame_write_sequencer

Overview:
- Column-level configuration controller that drives the FrameData/FrameStrobe chain feeding a fabric column of tiles.
- Accepts a 32-bit configuration word stream over valid/ready and locks onto a sync word.
- Decodes frame-write headers, assembles one data word per row, then issues a timed one-hot FrameStrobe pulse with FrameData held stable around it.
- Sits between the bitstream source (config port / emulation loader) and the column's FrameData/FrameStrobe inputs.

Parameters:
- MaxFramesPerCol, 20, number of frames per column; width of FrameStrobe.
- FrameBitsPerRow, 32, FrameData bits per tile row; equals config word width.
- NumRows, 4, tile rows in the column; data words per frame.
- StrobeCycles, 1, cycles FrameStrobe stays asserted (legal range 1..15).
- SyncWord, 32'hFAB0_FAB1, stream synchronisation word.

Ports:
- UserCLK  input  1  clock.
- Reset  input  1  asynchronous, active-high reset.
- cfg_word  input  FrameBitsPerRow  incoming configuration word.
- cfg_valid  input  1  cfg_word valid.
- cfg_ready  output  1  sequencer accepts word this cycle.
- FrameData  output  NumRows*FrameBitsPerRow  row data; row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  output  MaxFramesPerCol  one-hot frame write strobe.
- busy  output  1  high in any state other than IDLE.
- frame_count  output  16  frames successfully strobed since reset; saturates at 16'hFFFF.
- err  output  1  sticky bad-header/bad-index flag.

Behaviour:
- Reset (async, any state): state=IDLE; FrameData=0; FrameStrobe=0; frame_count=0; err=0; cfg_ready=1; busy=0. All internal counters are cleared. A reset mid-strobe drops FrameStrobe immediately.
- Transfer: a word is consumed when cfg_valid && cfg_ready are high on a UserCLK edge. cfg_ready is combinational from state only and never depends on cfg_valid.
- States: IDLE, HEADER, LOAD, SETUP, STROBE, HOLD.
- IDLE, cfg_ready=1:
  - Accepted word == SyncWord -> HEADER.
  - Any other word is discarded and the state stays IDLE.
- HEADER, cfg_ready=1. Accepted word is decoded with cmd = bits[31:24] and idx = bits[7:0]:
  - cmd 8'h01 with idx < MaxFramesPerCol: latch idx, row counter=0, skip=0 -> LOAD.
  - cmd 8'h01 with idx >= MaxFramesPerCol: err<=1, skip=1 -> LOAD. The frame's data words are still consumed.
  - cmd 8'h02 (desync) -> IDLE.
  - Any other cmd: err<=1, stay in HEADER.
- LOAD, cfg_ready=1:
  - Each accepted word is written into the row slot given by the row counter (row 0 first). The counter then increments.
  - When skip=1, the words are consumed but FrameData is not written.
  - After the NumRows-th word: skip=0 -> SETUP; skip=1 -> HEADER.
- SETUP, cfg_ready=0: 1 cycle with FrameData stable and FrameStrobe=0 -> STROBE.
- STROBE, cfg_ready=0:
  - FrameStrobe = one-hot (1 << idx) for exactly StrobeCycles cycles, counted by a cycle counter.
  - Then HOLD.
- HOLD, cfg_ready=0:
  - 1 cycle with FrameStrobe=0 and FrameData unchanged.
  - frame_count increments (saturating) -> HEADER.
- FrameData changes only in LOAD. It keeps its last value otherwise, including across desync.
- FrameStrobe is registered, never has more than one bit high, and is 0 outside STROBE.
- Latency: the first STROBE cycle starts 2 cycles after the edge that accepts the last data word (LOAD->SETUP edge, then SETUP->STROBE edge).
- Per-frame occupancy with continuous valid: 1 header + NumRows loads + 1 + StrobeCycles + 1 cycles.
- A cfg_valid drop mid-frame stalls in the current state with no timeout. The row counter is preserved.
- err clears only on Reset.

Test Plan:
- Reset, then send 32'h1234_5678 and then SyncWord -> first word dropped, busy rises on the cycle after the sync word is accepted, FrameStrobe stays 0.
- Send sync, hdr 32'h0100_0005, then rows 32'hA0..A3 -> FrameData={A3,A2,A1,A0}. FrameStrobe=20'h00020 for 1 cycle, 2 cycles after the last row is accepted. frame_count=1. cfg_ready is low for 3 cycles.
- Set StrobeCycles=3 and write frame idx 19 -> FrameStrobe=20'h80000 for exactly 3 cycles. Check it is one-hot every cycle.
- Send hdr idx 20 followed by 4 words -> err=1, no strobe, FrameData unchanged, frame_count unchanged. Then send a valid hdr idx 0 -> strobe 20'h00001.
- Toggle cfg_valid randomly during LOAD -> rows land in order and no word is lost or duplicated. Then send cmd 8'h02 -> IDLE, busy=0. A following header word without a new sync is ignored.
- Assert Reset during STROBE -> FrameStrobe=0 in the same cycle (async). All outputs return to their reset values and the next stream requires a new sync.

Source files
------------

// File: rtl/frame_write_sequencer.sv
// Column frame-write sequencer: locks onto a sync word, decodes frame headers, assembles NumRows row words, strobes one frame.
// Latency: first FrameStrobe cycle starts 2 cycles after the last row word is accepted; strobe lasts StrobeCycles cycles.
// Backpressure: cfg_ready is high only in IDLE/HEADER/LOAD and low while a frame is being written; a cfg_valid gap stalls in place.
module frame_write_sequencer #(
    parameter int                         MaxFramesPerCol = 20,
    parameter int                         FrameBitsPerRow = 32,
    parameter int                         NumRows         = 4,
    parameter int                         StrobeCycles    = 1,
    parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                 UserCLK,
    input  logic                                 Reset,
    input  logic [FrameBitsPerRow-1:0]           cfg_word,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic [15:0]                          frame_count,
    output logic                                 err
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t                              state_q, state_d;
    logic [RowW-1:0]                     row_q, row_d;
    logic [IdxW-1:0]                     idx_q, idx_d;
    logic                                skip_q, skip_d;
    logic [3:0]                          cnt_q, cnt_d;
    logic [NumRows*FrameBitsPerRow-1:0]  data_q, data_d;
    logic [MaxFramesPerCol-1:0]          strobe_q, strobe_d;
    logic [15:0]                         count_q, count_d;
    logic                                err_q, err_d;
    logic                                take;
    logic [7:0]                          cmd;
    logic [7:0]                          hdr_idx;

    // Ready depends on state only, so the source can present words without combinational loops.
    assign cfg_ready   = (state_q == IDLE) || (state_q == HEADER) || (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign take        = cfg_valid && cfg_ready;
    assign cmd         = cfg_word[31:24];
    assign hdr_idx     = cfg_word[7:0];
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign frame_count = count_q;
    assign err         = err_q;

    // Next-state and datapath updates; every register holds unless its state says otherwise.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        idx_d    = idx_q;
        skip_d   = skip_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        count_d  = count_q;
        err_d    = err_q;
        strobe_d = '0;

        case (state_q)
            IDLE: begin
                if (take && (cfg_word == SyncWord)) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (take) begin
                    if (cmd == 8'h01) begin
                        row_d   = '0;
                        state_d = LOAD;
                        if (hdr_idx < 8'(MaxFramesPerCol)) begin
                            idx_d  = hdr_idx[IdxW-1:0];
                            skip_d = 1'b0;
                        end else begin
                            // Out-of-range frame: still swallow its rows so the stream stays aligned.
                            err_d  = 1'b1;
                            skip_d = 1'b1;
                        end
                    end else if (cmd == 8'h02) begin
                        state_d = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (take) begin
                    if (!skip_q) begin
                        data_d[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = cfg_word;
                    end
                    if (row_q == RowW'(NumRows - 1)) begin
                        row_d   = '0;
                        state_d = skip_q ? HEADER : SETUP;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == 4'(StrobeCycles - 1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                state_d = HEADER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobe is registered: it is high exactly for the cycles spent in STROBE.
        if (state_d == STROBE) begin
            strobe_d[idx_q] = 1'b1;
        end
    end

    // State and datapath registers; reset drops the strobe immediately.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            idx_q    <= '0;
            skip_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            skip_q   <= skip_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule
